// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      FS_BOOT,
      FS_RUN,
      FS_HALTED
   } fetch_state_t;

   // Next-PC mux selector used between the FSM and pc_reg.
   typedef enum logic [1:0] {
      PC_HOLD,
      PC_INC,
      PC_REDIR
   } pc_sel_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter flop with a hold / increment / redirect next-PC mux.
module pc_reg
   import fetch_pkg::*;
#(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            reset_n,
   input  pc_sel_t         i_sel,
   input  logic [PC_W-1:0] i_target,
   output logic [PC_W-1:0] o_pc
);

   localparam logic [PC_W-1:0] W_STEP = PC_W'(PC_STEP);

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_next;

   // Increment wraps naturally at 2^PC_W.
   always_comb begin
      w_pc_next = r_pc;
      case (i_sel)
         PC_INC:   w_pc_next = r_pc + W_STEP;
         PC_REDIR: w_pc_next = i_target;
         default:  w_pc_next = r_pc;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_pc <= '0;
      else          r_pc <= w_pc_next;
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: BOOT/RUN/HALTED control, PC, IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic            halt,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [PC_W-1:0] id_pc,
   output logic [31:0]     id_instr,
   output logic            id_valid,
   output logic            halted,
   output logic            misalign_err,
   output logic [31:0]     fetch_count,
   output logic [31:0]     redirect_count
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_next;
   pc_sel_t         w_pc_sel;
   logic            w_load;
   logic            w_flush;
   logic            w_redirect;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_pc;
   logic [PC_W-1:0] r_id_pc;
   logic [31:0]     r_id_instr;
   logic            r_id_valid;
   logic            r_misalign;
   logic            w_unused;

   assign w_target = {BrPC[PC_W-1:2], 2'b00};
   assign w_unused = ^BrPC[31:PC_W];

   pc_reg #(.PC_W(PC_W)) u_pc_reg (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_sel    (w_pc_sel),
      .i_target (w_target),
      .o_pc     (w_pc)
   );

   assign imem_addr = w_pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= FS_BOOT;
      else          r_state <= w_state_next;
   end

   // Priority in RUN: halt, then redirect, then stall, else advance.
   always_comb begin
      w_state_next = r_state;
      w_pc_sel     = PC_HOLD;
      w_load       = 1'b0;
      w_flush      = 1'b0;
      w_redirect   = 1'b0;
      case (r_state)
         FS_BOOT: w_state_next = FS_RUN;
         FS_RUN: begin
            if (halt) begin
               w_state_next = FS_HALTED;
               w_flush      = 1'b1;
            end else if (PcSel) begin
               w_pc_sel   = PC_REDIR;
               w_flush    = 1'b1;
               w_redirect = 1'b1;
            end else if (!stall) begin
               w_pc_sel = PC_INC;
               w_load   = 1'b1;
            end
         end
         FS_HALTED: w_state_next = FS_HALTED;
         default:   w_state_next = FS_BOOT;
      endcase
   end

   // A flush bubbles the slot but keeps id_pc so it still names the last PC.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_id_pc    <= '0;
         r_id_instr <= NOP_INSTR;
         r_id_valid <= 1'b0;
      end else if (w_flush) begin
         r_id_instr <= NOP_INSTR;
         r_id_valid <= 1'b0;
      end else if (w_load) begin
         r_id_pc    <= w_pc;
         r_id_instr <= imem_rdata;
         r_id_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                             r_misalign <= 1'b0;
      else if (w_redirect && (BrPC[1:0] != 2'b00)) r_misalign <= 1'b1;
   end

   assign id_pc        = r_id_pc;
   assign id_instr     = r_id_instr;
   assign id_valid     = r_id_valid;
   assign halted       = (r_state == FS_HALTED);
   assign misalign_err = r_misalign;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_redir_cnt;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if (w_load && (r_fetch_cnt != 32'hFFFFFFFF))     r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_redirect && (r_redir_cnt != 32'hFFFFFFFF)) r_redir_cnt <= r_redir_cnt + 32'd1;
      end
   end

   assign fetch_count    = r_fetch_cnt;
   assign redirect_count = r_redir_cnt;
`else
   assign fetch_count    = 32'd0;
   assign redirect_count = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter PC_W, default 9, width of PC and instruction-memory address.
REQ-002 SHALL provide ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard hold request.
- PcSel  in  1  redirect request (taken branch, jump or halt).
- BrPC  in  32  redirect target.
- halt  in  1  halt request from decode.
- imem_addr  out  PC_W  current PC.
- imem_rdata  in  32  instruction at imem_addr, valid in the same cycle.
- id_pc  out  PC_W  PC of the instruction in IF/ID.
- id_instr  out  32  IF/ID instruction.
- id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  core halted.
- misalign_err  out  1  sticky misaligned-target flag.
- fetch_count  out  32  valid-fetch counter.
- redirect_count  out  32  redirect counter.
REQ-003 SHALL have exactly one clock and one asynchronous active-low reset; all state is clocked on the rising edge of clk.

Function
REQ-004 SHALL drive imem_addr combinationally from the PC register.
REQ-005 SHALL implement states BOOT, RUN and HALTED, evaluated in that priority:
- BOOT -> RUN unconditionally after one cycle; no IF/ID load in BOOT.
- RUN -> HALTED when halt=1.
- HALTED -> exit only by reset.
REQ-006 In RUN with halt=0, PcSel=0 and stall=0:
- PC <= PC+4, modulo 2^PC_W (wrap-around, no error).
- IF/ID <= {PC, imem_rdata}.
- id_valid <= 1.
REQ-007 In RUN with PcSel=1 and halt=0, regardless of stall:
- PC <= {BrPC[PC_W-1:2], 2'b00}.
- IF/ID flushed: id_instr = NOP, id_valid = 0, id_pc unchanged.
- redirect takes effect next cycle with exactly one bubble.
REQ-008 In RUN with stall=1, PcSel=0 and halt=0: PC, id_pc, id_instr and id_valid SHALL hold.
REQ-009 In RUN with halt=1, regardless of PcSel and stall:
- PC holds.
- IF/ID flushed.
- state -> HALTED; halted=1 from the next cycle.
REQ-010 In HALTED: PC and IF/ID hold; stall, PcSel, halt and BrPC are ignored.
REQ-011 SHALL truncate BrPC to PC_W bits; bits above PC_W-1 are ignored without error.
REQ-012 When a redirect is accepted and BrPC[1:0] != 0, misalign_err SHALL set on the next edge and stay set until reset.
REQ-013 In BOOT, stall, PcSel and halt SHALL be ignored.

Reset
REQ-014 SHALL, while reset_n=0, force:
- PC=0, state=BOOT.
- id_pc=0, id_instr=NOP (32'h00000013), id_valid=0.
- halted=0, misalign_err=0, fetch_count=0, redirect_count=0.
REQ-015 Reset asserted mid-operation (including HALTED) SHALL abandon state immediately, asynchronously.

Configuration
REQ-016 With FETCH_PERF_CNT_EN defined:
- fetch_count increments on each edge that loads IF/ID with id_valid=1.
- redirect_count increments on each accepted PcSel redirect.
- both saturate at 32'hFFFFFFFF.
REQ-017 Without FETCH_PERF_CNT_EN: both counter ports SHALL exist and be tied to 0, with no counter flops.

Structure
REQ-018 Package fetch_pkg SHALL hold:
- fetch_state_t enum {FS_BOOT, FS_RUN, FS_HALTED}.
- NOP_INSTR = 32'h00000013.
- PC_STEP = 4.
REQ-019 Sub-module pc_reg (PC flop plus next-PC mux: hold / +4 / redirect) SHALL be instantiated once; the FSM, IF/ID register and counters stay in fetch_stage.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- Release reset, imem returns addr-tagged words -> BOOT 1 cycle, then id_pc = 0, 4, 8 on consecutive cycles, id_valid=1.
- PC=0x1FC (PC_W=9), no redirect -> next PC=0x000, misalign_err stays 0.
- PcSel=1, BrPC=0x0000_0040, stall=1 -> PC=0x040 next cycle, id_valid=0, id_instr=0x00000013, redirect_count=1.
- stall=1 for 3 cycles at PC=0x010 -> imem_addr=0x010 and id_* unchanged throughout.
- BrPC=0x0000_0022, PcSel=1 -> PC=0x020, misalign_err=1 and sticky; then halt=1 -> halted=1 next cycle, PC frozen, PcSel ignored.
- reset_n low during HALTED -> all outputs return to REQ-014 values immediately.
